mastermind_solver: RTL and testbench

Automatic codebreaker, the guessing end of the guess/feedback exchange. Proposes 12-bit guesses (4 pegs × 3-bit colour) over a valid/ready handshake and consumes red/white peg feedback. Keeps a history of its guesses with their feedback. Each new guess is the lowest-numbered code consistent with the whole history. Used for self-play and as a bench opponent for the code-setting logic.

---
 rtl/mastermind_solver_pkg.sv | 27 ++
 rtl/mastermind_solver_if.sv | 22 ++
 rtl/mastermind_solver_peg_scorer.sv | 38 +++
 rtl/mastermind_solver.sv | 166 ++++++++++++++++
 tb/tb_mastermind_solver.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mastermind_solver_pkg.sv
// Shared types and constants for the Mastermind codebreaker and anything that scores codes.
package mastermind_solver_pkg;

  localparam int PEG_BITS    = 3;
  localparam int NUM_PEGS    = 4;
  localparam int CODE_W      = PEG_BITS * NUM_PEGS;
  localparam int NUM_COLOURS = 1 << PEG_BITS;
  localparam int FB_W        = 3;
  localparam int HIST_DEPTH  = 16;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [FB_W-1:0]   fb_t;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    PROPOSE,
    WAIT_FB,
    SOLVED,
    FAILED
  } state_t;

  function automatic logic [PEG_BITS-1:0] peg_of(input code_t code, input int idx);
    return code[idx*PEG_BITS +: PEG_BITS];
  endfunction

endpackage

// File: rtl/mastermind_solver_if.sv
// Guess/feedback exchange between the codebreaker (master) and the code setter (slave).
interface mastermind_solver_if;
  import mastermind_solver_pkg::*;

  code_t guess;
  logic  guess_valid;
  logic  guess_ready;
  logic  fb_valid;
  fb_t   fb_red;
  fb_t   fb_white;

  modport master (
    output guess, guess_valid,
    input  guess_ready, fb_valid, fb_red, fb_white
  );

  modport slave (
    input  guess, guess_valid,
    output guess_ready, fb_valid, fb_red, fb_white
  );

endinterface

// File: rtl/mastermind_solver_peg_scorer.sv
// Combinational Mastermind scorer: red = exact position matches, white = shared colours minus red.
module peg_scorer
  import mastermind_solver_pkg::*;
(
  input  code_t code_a,
  input  code_t code_b,
  output fb_t   red,
  output fb_t   white
);

  fb_t red_acc;
  fb_t common;
  fb_t cnt_a;
  fb_t cnt_b;

  always_comb begin
    red_acc = '0;
    common  = '0;
    cnt_a   = '0;
    cnt_b   = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (peg_of(code_a, p) == peg_of(code_b, p)) red_acc = red_acc + fb_t'(1);
    end
    // Per colour, the pair shares min(count_a, count_b) pegs regardless of position.
    for (int c = 0; c < NUM_COLOURS; c++) begin
      cnt_a = '0;
      cnt_b = '0;
      for (int p = 0; p < NUM_PEGS; p++) begin
        if (peg_of(code_a, p) == PEG_BITS'(c)) cnt_a = cnt_a + fb_t'(1);
        if (peg_of(code_b, p) == PEG_BITS'(c)) cnt_b = cnt_b + fb_t'(1);
      end
      common = common + ((cnt_a < cnt_b) ? cnt_a : cnt_b);
    end
    red   = red_acc;
    white = common - red_acc;
  end

endmodule

// File: rtl/mastermind_solver.sv
// Automatic codebreaker: each guess is the lowest code consistent with every (guess, feedback) pair so far.
module mastermind_solver
  import mastermind_solver_pkg::*;
#(
  parameter int MAX_GUESSES = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  mastermind_solver_if.master bus,
  output logic [3:0]          guess_num,
  output logic                busy,
  output logic                solved,
  output logic                failed
);

  localparam logic [3:0]    MAX_G     = 4'(MAX_GUESSES);
  localparam logic [FB_W:0] PEG_LIMIT = (FB_W+1)'(NUM_PEGS);

  state_t     state, state_n;
  code_t      cand, cand_n;
  code_t      guess_q, guess_n;
  logic [3:0] k, k_n;
  logic [3:0] count, count_n;
  logic [3:0] guess_num_n;
  logic       guess_valid_q, guess_valid_n;
  logic       busy_n, solved_n, failed_n;
  logic       hist_we;

  code_t hist_guess [HIST_DEPTH];
  fb_t   hist_red   [HIST_DEPTH];
  fb_t   hist_white [HIST_DEPTH];

  fb_t           sc_red, sc_white;
  logic          hit;
  logic [FB_W:0] fb_sum;

  peg_scorer u_scorer (
    .code_a (cand),
    .code_b (hist_guess[k]),
    .red    (sc_red),
    .white  (sc_white)
  );

  assign hit    = (sc_red == hist_red[k]) && (sc_white == hist_white[k]);
  assign fb_sum = {1'b0, bus.fb_red} + {1'b0, bus.fb_white};

  assign bus.guess       = guess_q;
  assign bus.guess_valid = guess_valid_q;

  always_comb begin
    state_n       = state;
    cand_n        = cand;
    k_n           = k;
    count_n       = count;
    guess_n       = guess_q;
    guess_valid_n = guess_valid_q;
    guess_num_n   = guess_num;
    solved_n      = solved;
    failed_n      = failed;
    hist_we       = 1'b0;

    case (state)
      IDLE, SOLVED, FAILED: begin
        if (start) begin
          state_n     = SEARCH;
          cand_n      = '0;
          k_n         = '0;
          count_n     = '0;
          guess_num_n = '0;
          solved_n    = 1'b0;
          failed_n    = 1'b0;
        end
      end

      // One history entry is checked per cycle; any mismatch moves on to the next candidate.
      SEARCH: begin
        if ((count == '0) || (hit && (k == count - 4'd1))) begin
          state_n       = PROPOSE;
          guess_n       = cand;
          guess_valid_n = 1'b1;
        end else if (hit) begin
          k_n = k + 4'd1;
        end else if (cand == '1) begin
          state_n  = FAILED;
          failed_n = 1'b1;
        end else begin
          cand_n = cand + code_t'(1);
          k_n    = '0;
        end
      end

      PROPOSE: begin
        if (guess_valid_q && bus.guess_ready) begin
          guess_valid_n = 1'b0;
          guess_num_n   = guess_num + 4'd1;
          state_n       = WAIT_FB;
        end
      end

      // The last code in the space cannot be followed by a resumed search, so it ends the game.
      WAIT_FB: begin
        if (bus.fb_valid) begin
          if (fb_sum > PEG_LIMIT) begin
            state_n  = FAILED;
            failed_n = 1'b1;
          end else if (bus.fb_red == fb_t'(NUM_PEGS)) begin
            state_n  = SOLVED;
            solved_n = 1'b1;
          end else begin
            hist_we = 1'b1;
            count_n = count + 4'd1;
            if ((guess_num == MAX_G) || (cand == '1)) begin
              state_n  = FAILED;
              failed_n = 1'b1;
            end else begin
              cand_n  = cand + code_t'(1);
              k_n     = '0;
              state_n = SEARCH;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n == SEARCH) || (state_n == PROPOSE) || (state_n == WAIT_FB);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cand          <= '0;
      k             <= '0;
      count         <= '0;
      guess_q       <= '0;
      guess_valid_q <= 1'b0;
      guess_num     <= '0;
      busy          <= 1'b0;
      solved        <= 1'b0;
      failed        <= 1'b0;
    end else begin
      state         <= state_n;
      cand          <= cand_n;
      k             <= k_n;
      count         <= count_n;
      guess_q       <= guess_n;
      guess_valid_q <= guess_valid_n;
      guess_num     <= guess_num_n;
      busy          <= busy_n;
      solved        <= solved_n;
      failed        <= failed_n;
    end
  end

  // History contents need no reset: entries at or above count are never read.
  always_ff @(posedge clk) begin
    if (hist_we) begin
      hist_guess[count] <= cand;
      hist_red[count]   <= bus.fb_red;
      hist_white[count] <= bus.fb_white;
    end
  end

endmodule

// File: tb/tb_mastermind_solver.sv
// Bench for mastermind_solver: directed games plus random secrets against a brute-force reference.
module tb_mastermind_solver;
  import mastermind_solver_pkg::*;

  localparam int WAIT_LIMIT = 30000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       guess_ready = 1'b0;
  logic       fb_valid = 1'b0;
  logic [2:0] fb_red = '0;
  logic [2:0] fb_white = '0;
  logic       sel_b = 1'b0;

  logic [3:0] num_a, num_b;
  logic       busy_a, busy_b, solved_a, solved_b, failed_a, failed_b;

  int n_checks = 0;
  int n_pass = 0;

  logic [11:0] hist_g [$];
  logic [5:0]  hist_fb [$];

  mastermind_solver_if bus_a ();
  mastermind_solver_if bus_b ();

  assign bus_a.guess_ready = guess_ready;
  assign bus_a.fb_valid    = fb_valid;
  assign bus_a.fb_red      = fb_red;
  assign bus_a.fb_white    = fb_white;
  assign bus_b.guess_ready = guess_ready;
  assign bus_b.fb_valid    = fb_valid;
  assign bus_b.fb_red      = fb_red;
  assign bus_b.fb_white    = fb_white;

  mastermind_solver #(.MAX_GUESSES(15)) dut_a (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start_a),
    .bus       (bus_a),
    .guess_num (num_a),
    .busy      (busy_a),
    .solved    (solved_a),
    .failed    (failed_a)
  );

  mastermind_solver #(.MAX_GUESSES(2)) dut_b (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start_b),
    .bus       (bus_b),
    .guess_num (num_b),
    .busy      (busy_b),
    .solved    (solved_b),
    .failed    (failed_b)
  );

  logic [11:0] m_guess;
  logic        m_valid, m_busy, m_solved, m_failed;
  logic [3:0]  m_num;

  assign m_guess  = sel_b ? bus_b.guess       : bus_a.guess;
  assign m_valid  = sel_b ? bus_b.guess_valid : bus_a.guess_valid;
  assign m_num    = sel_b ? num_b    : num_a;
  assign m_busy   = sel_b ? busy_b   : busy_a;
  assign m_solved = sel_b ? solved_b : solved_a;
  assign m_failed = sel_b ? failed_b : failed_a;

  always #5 clk = ~clk;

  // Reference score from the game rules: {red, white}.
  function automatic logic [5:0] ref_score(input logic [11:0] a, input logic [11:0] b);
    int ca [8];
    int cb [8];
    int red;
    int common;
    logic [2:0] pa, pb;
    red = 0;
    common = 0;
    for (int c = 0; c < 8; c++) begin
      ca[c] = 0;
      cb[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      pa = a[3*i +: 3];
      pb = b[3*i +: 3];
      if (pa == pb) red++;
      ca[pa]++;
      cb[pb]++;
    end
    for (int c = 0; c < 8; c++) common += (ca[c] < cb[c]) ? ca[c] : cb[c];
    return {3'(red), 3'(common - red)};
  endfunction

  // Lowest code in the whole space consistent with the history; bit 12 set when none exists.
  function automatic logic [12:0] ref_next();
    bit ok;
    for (int c = 0; c < 4096; c++) begin
      ok = 1'b1;
      for (int i = 0; i < hist_g.size() && ok; i++) begin
        if (ref_score(12'(c), hist_g[i]) != hist_fb[i]) ok = 1'b0;
      end
      if (ok) return {1'b0, 12'(c)};
    end
    return 13'h1000;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic apply_stimulus();
    if (sel_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_guess(output bit ok);
    int i;
    i = 0;
    while (!m_valid && i < WAIT_LIMIT) begin
      @(negedge clk);
      i++;
    end
    ok = m_valid;
    check_output("guess_valid_arrives", 32'(ok), 32'd1);
  endtask

  task automatic handshake();
    guess_ready = 1'b1;
    @(negedge clk);
    guess_ready = 1'b0;
  endtask

  task automatic send_fb(input logic [2:0] red, input logic [2:0] white);
    fb_valid = 1'b1;
    fb_red   = red;
    fb_white = white;
    @(negedge clk);
    fb_valid = 1'b0;
  endtask

  task automatic play_game(input logic [11:0] secret, input int max_g, input int stall, input bit inject);
    bit          ok;
    logic [12:0] expv;
    logic [5:0]  fb;
    hist_g.delete();
    hist_fb.delete();
    for (int n = 0; n < max_g; n++) begin
      wait_guess(ok);
      if (!ok) return;
      expv = ref_next();
      check_output("guess_lowest_consistent", 32'(m_guess), 32'(expv));
      check_output("guess_num_in_propose", 32'(m_num), 32'(n));
      if (n == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check_output("stall_guess_stable", 32'(m_guess), 32'(expv));
          check_output("stall_valid_stable", 32'(m_valid), 32'd1);
        end
      end
      handshake();
      check_output("valid_drops_after_accept", 32'(m_valid), 32'd0);
      check_output("guess_num_after_accept", 32'(m_num), 32'(n + 1));
      fb = ref_score(m_guess, secret);
      send_fb(fb[5:3], fb[2:0]);
      if (fb[5:3] == 3'd4) begin
        check_output("solved_on_win", 32'(m_solved), 32'd1);
        check_output("busy_low_on_win", 32'(m_busy), 32'd0);
        return;
      end
      if (n + 1 == max_g) begin
        check_output("failed_on_budget", 32'(m_failed), 32'd1);
        check_output("busy_low_on_fail", 32'(m_busy), 32'd0);
        return;
      end
      check_output("busy_while_searching", 32'(m_busy), 32'd1);
      hist_g.push_back(m_guess);
      hist_fb.push_back(fb);
      if (inject && n == 0) begin
        send_fb(3'd4, 3'd0);
        check_output("stray_fb_ignored", 32'(m_solved), 32'd0);
      end
    end
  endtask

  initial begin
    bit          ok;
    logic [11:0] secret;

    repeat (2) @(negedge clk);
    check_output("rst_guess", 32'(bus_a.guess), 32'd0);
    check_output("rst_valid", 32'(bus_a.guess_valid), 32'd0);
    check_output("rst_num", 32'(num_a), 32'd0);
    check_output("rst_busy", 32'(busy_a), 32'd0);
    check_output("rst_solved", 32'(solved_a), 32'd0);
    check_output("rst_failed", 32'(failed_a), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] secret 000 and start latency");
    apply_stimulus();
    check_output("latency_cycle1_valid", 32'(m_valid), 32'd0);
    check_output("latency_cycle1_busy", 32'(m_busy), 32'd1);
    @(negedge clk);
    check_output("latency_cycle2_valid", 32'(m_valid), 32'd1);
    check_output("first_guess_zero", 32'(m_guess), 32'd0);
    play_game(12'h000, 15, 0, 1'b0);
    check_output("s000_guess_num", 32'(m_num), 32'd1);
    check_output("s000_guess_held", 32'(m_guess), 32'd0);

    $display("[TB] secret 001");
    apply_stimulus();
    check_output("restart_clears_solved", 32'(m_solved), 32'd0);
    check_output("restart_clears_num", 32'(m_num), 32'd0);
    play_game(12'h001, 15, 0, 1'b0);
    check_output("s001_guess_num", 32'(m_num), 32'd2);
    check_output("s001_final_guess", 32'(m_guess), 32'h001);

    $display("[TB] back-pressure and stray feedback");
    apply_stimulus();
    play_game(12'h6d3, 15, 10, 1'b1);
    check_output("bp_solved", 32'(m_solved), 32'd1);

    $display("[TB] invalid feedback");
    apply_stimulus();
    wait_guess(ok);
    handshake();
    send_fb(3'd3, 3'd2);
    check_output("bad_fb_failed", 32'(m_failed), 32'd1);
    check_output("bad_fb_not_solved", 32'(m_solved), 32'd0);
    check_output("bad_fb_not_busy", 32'(m_busy), 32'd0);
    apply_stimulus();
    check_output("restart_clears_failed", 32'(m_failed), 32'd0);
    wait_guess(ok);
    check_output("restart_guess_zero", 32'(m_guess), 32'd0);
    check_output("restart_num_zero", 32'(m_num), 32'd0);
    handshake();
    send_fb(3'd4, 3'd0);
    check_output("restart_solved", 32'(m_solved), 32'd1);

    $display("[TB] guess budget of 2, secret 777");
    sel_b = 1'b1;
    apply_stimulus();
    play_game(12'h777, 2, 0, 1'b0);
    check_output("budget_failed", 32'(m_failed), 32'd1);
    check_output("budget_guess_num", 32'(m_num), 32'd2);
    check_output("budget_not_solved", 32'(m_solved), 32'd0);
    sel_b = 1'b0;

    $display("[TB] random secrets");
    for (int g = 0; g < 4; g++) begin
      secret = 12'($urandom_range(0, 4095));
      apply_stimulus();
      play_game(secret, 15, 0, 1'b0);
      check_output("rand_solved", 32'(m_solved), 32'd1);
      check_output("rand_final_guess", 32'(m_guess), 32'(secret));
    end

    $display("[TB] reset during search");
    apply_stimulus();
    wait_guess(ok);
    handshake();
    send_fb(3'd0, 3'd0);
    repeat (3) @(negedge clk);
    check_output("pre_reset_busy", 32'(busy_a), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_output("async_rst_guess", 32'(bus_a.guess), 32'd0);
    check_output("async_rst_valid", 32'(bus_a.guess_valid), 32'd0);
    check_output("async_rst_num", 32'(num_a), 32'd0);
    check_output("async_rst_busy", 32'(busy_a), 32'd0);
    check_output("async_rst_solved", 32'(solved_a), 32'd0);
    check_output("async_rst_failed", 32'(failed_a), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    apply_stimulus();
    wait_guess(ok);
    check_output("post_rst_guess", 32'(m_guess), 32'd0);
    check_output("post_rst_num", 32'(m_num), 32'd0);
    handshake();
    send_fb(3'd4, 3'd0);
    check_output("post_rst_solved", 32'(m_solved), 32'd1);
    check_output("post_rst_num_final", 32'(m_num), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
